// File: rtl/act_skew_feeder_if.sv
// Port bundle for the activation skew feeder: tile-buffer write port,
// start/enable control and the skewed lane outputs toward the PE array.
interface act_skew_feeder_if #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int ROW_W  = 2,
    parameter int ADDR_W = 2
);
    logic                   en;
    logic                   wr_en;
    logic [ROW_W-1:0]       wr_row;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   start;
    logic [ROWS*DATA_W-1:0] act_out;
    logic [ROWS-1:0]        act_vld;
    logic                   busy;
    logic                   done;

    modport master (
        output en, wr_en, wr_row, wr_addr, wr_data, start,
        input  act_out, act_vld, busy, done
    );

    modport slave (
        input  en, wr_en, wr_row, wr_addr, wr_data, start,
        output act_out, act_vld, busy, done
    );
endinterface

// File: rtl/act_skew_feeder.sv
// Buffers one ROWS x DEPTH activation tile and streams it into the left edge
// of the systolic array, delaying row r by r cycles (diagonal skew).
module act_skew_feeder #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 4,
    parameter int ROW_W  = 2,
    parameter int ADDR_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    act_skew_feeder_if.slave bus
);
    localparam int N   = DEPTH + ROWS - 1;
    localparam int T_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [T_W-1:0]         t_reg, t_next;
    logic [ROWS*DATA_W-1:0] act_reg, act_next;
    logic [ROWS-1:0]        vld_reg, vld_next;
    logic                   done_reg, done_next;

    logic [DATA_W-1:0]      buf_mem [ROWS][DEPTH];
    logic [ROWS*DATA_W-1:0] lane_data;
    logic [ROWS-1:0]        lane_hit;
    logic [ROW_W-1:0]       wr_row_idx;
    logic [ADDR_W-1:0]      wr_addr_idx;

    assign wr_row_idx  = bus.wr_row;
    assign wr_addr_idx = bus.wr_addr;

    // The buffer is only writable while idle so a running stream never sees
    // a half-updated tile; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.en && bus.wr_en && state_reg == IDLE) begin
            buf_mem[wr_row_idx][wr_addr_idx] <= bus.wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_lane
            // rel = t - row; its top bit flags a negative offset
            logic [T_W:0] rel;
            assign rel          = {1'b0, t_reg} - (T_W + 1)'(gi);
            assign lane_hit[gi] = !rel[T_W] && (rel < (T_W + 1)'(DEPTH));
            assign lane_data[gi*DATA_W +: DATA_W] =
                lane_hit[gi] ? buf_mem[gi][rel[ADDR_W-1:0]] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            t_reg     <= '0;
            act_reg   <= '0;
            vld_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            act_reg   <= act_next;
            vld_reg   <= vld_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        act_next   = act_reg;
        vld_next   = vld_reg;
        done_next  = done_reg;
        if (bus.en) begin
            done_next = 1'b0;
            case (state_reg)
                IDLE: begin
                    act_next = '0;
                    vld_next = '0;
                    if (bus.start) begin
                        state_next = STREAM;
                        t_next     = '0;
                    end
                end
                STREAM: begin
                    act_next = lane_data;
                    vld_next = lane_hit;
                    t_next   = t_reg + 1'b1;
                    if (t_reg == T_W'(N - 1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    act_next   = '0;
                    vld_next   = '0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.act_out = act_reg;
    assign bus.act_vld = vld_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder: expected per-cycle output frames are
// queued when a tile is launched and popped on every enabled clock edge.
module tb_act_skew_feeder;
    localparam int DATA_W = 16;
    localparam int ROWS   = 4;
    localparam int DEPTH  = 4;
    localparam int ROW_W  = 2;
    localparam int ADDR_W = 2;
    localparam int N      = DEPTH + ROWS - 1;

    typedef struct packed {
        logic [ROWS*DATA_W-1:0] act;
        logic [ROWS-1:0]        vld;
        logic                   busy;
        logic                   done;
    } frame_t;

    logic clk;
    logic rst_n;

    act_skew_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

    act_skew_feeder #(
        .DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int unsigned       n_assert = 0;
    int unsigned       n_fail   = 0;
    frame_t            exp_q[$];
    frame_t            last_exp;
    frame_t            idle_frame;
    logic [DATA_W-1:0] tile [ROWS][DEPTH];

    task automatic check_frame(input string tag, input frame_t e);
        n_assert++;
        assert (bus.act_out === e.act) else begin
            n_fail++;
            $error("FAIL %s act_out: observed %h expected %h", tag, bus.act_out, e.act);
        end
        n_assert++;
        assert (bus.act_vld === e.vld) else begin
            n_fail++;
            $error("FAIL %s act_vld: observed %b expected %b", tag, bus.act_vld, e.vld);
        end
        n_assert++;
        assert (bus.busy === e.busy) else begin
            n_fail++;
            $error("FAIL %s busy: observed %b expected %b", tag, bus.busy, e.busy);
        end
        n_assert++;
        assert (bus.done === e.done) else begin
            n_fail++;
            $error("FAIL %s done: observed %b expected %b", tag, bus.done, e.done);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns later. A disabled edge must
    // leave every output exactly as it was.
    task automatic tick(input string tag);
        frame_t e;
        @(posedge clk);
        #1;
        if (bus.en === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_frame;
            last_exp = e;
        end else begin
            e = last_exp;
        end
        check_frame(tag, e);
    endtask

    // Frame j is what the outputs show after edge E0+j: element k of row r
    // lands after E0+1+k+r, done follows one cycle after the last slot.
    task automatic push_tile();
        frame_t f;
        int     k;
        for (int j = 0; j <= N + 1; j++) begin
            f = '0;
            if (j >= 1 && j <= N) begin
                for (int r = 0; r < ROWS; r++) begin
                    k = j - 1 - r;
                    if (k >= 0 && k < DEPTH) begin
                        f.act[r*DATA_W +: DATA_W] = tile[r][k];
                        f.vld[r] = 1'b1;
                    end
                end
            end
            f.busy = (j <= N);
            f.done = (j == N + 1);
            exp_q.push_back(f);
        end
    endtask

    task automatic write_buf(input int r, input int k, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = ROW_W'(r);
        bus.wr_addr = ADDR_W'(k);
        bus.wr_data = d;
        if (bus.en === 1'b1) tile[r][k] = d;
        tick("write");
        bus.wr_en = 1'b0;
    endtask

    task automatic launch(input string tag);
        bus.start = 1'b1;
        push_tile();
        tick(tag);
        bus.start = 1'b0;
    endtask

    initial begin
        idle_frame  = '0;
        last_exp    = '0;
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_row  = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        #2;
        check_frame("reset", idle_frame);
        #23;
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) tick("idle");

        // Basic skew; the final write shares its edge with start
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!(r == ROWS - 1 && k == DEPTH - 1))
                    write_buf(r, k, DATA_W'(16'h0100 * r + k + 1));
            end
        end
        bus.wr_en   = 1'b1;
        bus.wr_row  = ROW_W'(ROWS - 1);
        bus.wr_addr = ADDR_W'(DEPTH - 1);
        bus.wr_data = 16'h0304;
        tile[ROWS-1][DEPTH-1] = 16'h0304;
        bus.start = 1'b1;
        push_tile();
        tick("skew_e0");
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int i = 0; i < N + 3; i++) tick("skew");

        // Enable stall after E0+3
        launch("stall_e0");
        for (int i = 0; i < 3; i++) tick("stall_pre");
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) tick("stall_hold");
        bus.en = 1'b1;
        for (int i = 0; i < N - 1; i++) tick("stall_post");
        tick("stall_idle");

        // Writes and start during STREAM are dropped
        launch("prot_e0");
        tick("prot");
        tick("prot");
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd1;
        bus.wr_addr = 2'd2;
        bus.wr_data = 16'hFFFF;
        bus.start   = 1'b1;
        tick("prot_wr");
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < N - 2; i++) tick("prot");
        tick("prot_nodup");
        tick("prot_nodup");
        launch("prot_re_e0");
        for (int i = 0; i < N + 2; i++) tick("prot_re");

        // Back-to-back with start held high
        bus.start = 1'b1;
        push_tile();
        push_tile();
        for (int i = 0; i < N + 3; i++) tick("b2b");
        bus.start = 1'b0;
        for (int i = 0; i < N + 1; i++) tick("b2b");
        tick("b2b_idle");

        // en=0 blocks writes and start
        bus.en      = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 16'hDEAD;
        bus.start   = 1'b1;
        tick("en_low");
        tick("en_low");
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        bus.en    = 1'b1;
        tick("en_low_after");

        // Asynchronous reset after E0+5
        launch("rst_e0");
        for (int i = 0; i < 5; i++) tick("rst_pre");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        last_exp = idle_frame;
        check_frame("rst_async", idle_frame);
        tick("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) tick("rst_nodone");
        launch("replay_e0");
        for (int i = 0; i < N + 2; i++) tick("replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
